// File: rtl/ibuff_dispatch_ctrl_pkg.sv
// Shared constants and types for the instruction-buffer dispatch controller.
// Build-wide width macros get fallbacks here so that standalone compiles still elaborate.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

package ibuff_dispatch_ctrl_pkg;

   localparam int unsigned IB_DEF_DEPTH = 16;
   localparam int unsigned IB_DEF_INDEX = 4;
   localparam int unsigned IB_DEF_LANES = `DISPATCH_WIDTH;
   localparam int unsigned IB_OCC_W     = IB_DEF_INDEX + 1;

   typedef logic [IB_DEF_INDEX-1:0]   ib_addr_t;
   typedef ib_addr_t [IB_DEF_LANES-1:0] ib_rd_addr_t;

   // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the index.
   function automatic int unsigned occ_width(input int unsigned index);
      return index + 1;
   endfunction

endpackage

// File: rtl/ibuff_ptr_adder.sv
// Mod-DEPTH lane-address generator: lane i = base + i, wrapping by INDEX-bit overflow.
module ibuff_ptr_adder #(
   parameter int unsigned INDEX = 4,
   parameter int unsigned LANES = 4
) (
   input  logic [INDEX-1:0]       base_i,
   output logic [LANES*INDEX-1:0] addr_o
);

   always_comb begin
      addr_o = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         addr_o[i*INDEX +: INDEX] = base_i + INDEX'(i);
      end
   end

endmodule

// File: rtl/ibuff_dispatch_ctrl.sv
// Head/tail/occupancy controller for the instruction buffer; dispatches only full bundles.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

module ibuff_dispatch_ctrl
   import ibuff_dispatch_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned INDEX          = 4,
   parameter int unsigned DISPATCH_WIDTH = `DISPATCH_WIDTH,
   parameter int unsigned WR_LANES       = 2 * `FETCH_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush_i,
   input  logic [$clog2(WR_LANES+1)-1:0]     push_cnt_i,
   input  logic                              dispatch_ready_i,
   output logic [INDEX-1:0]                  tail_o,
   output logic                              stall_o,
   output logic [DISPATCH_WIDTH*INDEX-1:0]   rd_addr_o,
   output logic                              bundle_valid_o,
   output logic [INDEX:0]                    count_o,
   output logic                              overflow_err_o
);

   localparam int unsigned OCC_W = occ_width(INDEX);
   localparam int unsigned SUM_W = OCC_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
   localparam logic [SUM_W-1:0] DW_S    = SUM_W'(DISPATCH_WIDTH);
   localparam logic [SUM_W-1:0] WR_S    = SUM_W'(WR_LANES);

   logic [INDEX-1:0] head_q, head_d;
   logic [INDEX-1:0] tail_q, tail_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   logic [SUM_W-1:0] count_s, push_s, pop_s, sum_s;
   logic             valid, stall, push_req, push_ok;

   always_comb begin
      count_s  = SUM_W'(count_q);
      push_s   = SUM_W'(push_cnt_i);
      valid    = count_s >= DW_S;
      stall    = (DEPTH_S - count_s) < WR_S;
      pop_s    = (valid && dispatch_ready_i) ? DW_S : '0;
      push_req = push_s != '0;
      sum_s    = count_s + push_s - pop_s;
      // A rejected push still lets the pop proceed; only the push is dropped.
      push_ok  = push_req && !stall && (sum_s <= DEPTH_S);

      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + INDEX'(pop_s);
         tail_d  = push_ok ? tail_q + INDEX'(push_s) : tail_q;
         count_d = OCC_W'(push_ok ? sum_s : count_s - pop_s);
         err_d   = err_q | (push_req & ~push_ok);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   ibuff_ptr_adder #(
      .INDEX (INDEX),
      .LANES (DISPATCH_WIDTH)
   ) u_rd_addr (
      .base_i (head_q),
      .addr_o (rd_addr_o)
   );

   assign tail_o         = tail_q;
   assign count_o        = count_q;
   assign stall_o        = stall;
   assign bundle_valid_o = valid;
   assign overflow_err_o = err_q;

endmodule

// File: tb/tb_ibuff_dispatch_ctrl.sv
// Self-checking bench for ibuff_dispatch_ctrl (DEPTH=16, DISPATCH_WIDTH=4, WR_LANES=4).
module tb_ibuff_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_i;
   logic [2:0]  push_cnt_i;
   logic        dispatch_ready_i;
   logic [3:0]  tail_o;
   logic        stall_o;
   logic [15:0] rd_addr_o;
   logic        bundle_valid_o;
   logic [4:0]  count_o;
   logic        overflow_err_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, in plain integers.
   int m_count, m_head, m_tail;
   bit m_err;

   ibuff_dispatch_ctrl #(
      .DEPTH          (16),
      .INDEX          (4),
      .DISPATCH_WIDTH (4),
      .WR_LANES       (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .flush_i          (flush_i),
      .push_cnt_i       (push_cnt_i),
      .dispatch_ready_i (dispatch_ready_i),
      .tail_o           (tail_o),
      .stall_o          (stall_o),
      .rd_addr_o        (rd_addr_o),
      .bundle_valid_o   (bundle_valid_o),
      .count_o          (count_o),
      .overflow_err_o   (overflow_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] exp_rd();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'((m_head + i) % 16);
      return v;
   endfunction

   function automatic void model_reset();
      m_count = 0; m_head = 0; m_tail = 0; m_err = 0;
   endfunction

   // Applies one cycle of stimulus (called at posedge+1) and advances the model.
   task automatic cycle(input int p, input bit r, input bit f);
      int pop;
      bit stl, bad;
      push_cnt_i = 3'(p);
      dispatch_ready_i = r;
      flush_i = f;
      pop = (m_count >= 4 && r) ? 4 : 0;
      stl = (16 - m_count) < 4;
      if (f) begin
         m_count = 0; m_head = 0; m_tail = 0;
      end else begin
         bad = (p != 0) && (stl || (m_count + p - pop > 16));
         if (bad) m_err = 1;
         else begin
            m_count += p;
            m_tail = (m_tail + p) % 16;
         end
         m_count -= pop;
         m_head = (m_head + pop) % 16;
      end
      @(posedge clk);
      #1;
      push_cnt_i = '0;
      dispatch_ready_i = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count_o); end
      n_cmp++; if (tail_o !== 4'd0) begin n_bad++; $display("FAIL reset_tail got %0d exp 0", tail_o); end
      n_cmp++; if (rd_addr_o !== 16'h3210) begin n_bad++; $display("FAIL reset_rd got %h exp 3210", rd_addr_o); end
      n_cmp++; if (bundle_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", bundle_valid_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall_o); end
      n_cmp++; if (overflow_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", overflow_err_o); end
   endtask

   task automatic test_fill();
      apply_reset();
      cycle(3, 0, 0);
      n_cmp++; if (count_o !== 5'd3) begin n_bad++; $display("FAIL fill3_count got %0d exp 3", count_o); end
      n_cmp++; if (bundle_valid_o !== 1'b0) begin n_bad++; $display("FAIL fill3_valid got %b exp 0", bundle_valid_o); end
      n_cmp++; if (tail_o !== 4'd3) begin n_bad++; $display("FAIL fill3_tail got %0d exp 3", tail_o); end
      cycle(1, 0, 0);
      n_cmp++; if (bundle_valid_o !== 1'b1) begin n_bad++; $display("FAIL fill4_valid got %b exp 1", bundle_valid_o); end
      n_cmp++; if (rd_addr_o !== 16'h3210) begin n_bad++; $display("FAIL fill4_rd got %h exp 3210", rd_addr_o); end
   endtask

   // Head can only sit on multiples of DISPATCH_WIDTH, so the wrap is exercised from head=12.
   task automatic test_wrap();
      apply_reset();
      cycle(4, 0, 0);
      repeat (3) cycle(4, 1, 0);
      cycle(4, 0, 0);
      cycle(4, 0, 0);
      n_cmp++; if (count_o !== 5'd12) begin n_bad++; $display("FAIL wrap_count12 got %0d exp 12", count_o); end
      n_cmp++; if (rd_addr_o !== 16'hFEDC) begin n_bad++; $display("FAIL wrap_rd_pre got %h exp fedc", rd_addr_o); end
      n_cmp++; if (tail_o !== 4'd8) begin n_bad++; $display("FAIL wrap_tail got %0d exp 8", tail_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL stall_at12 got %b exp 0", stall_o); end
      cycle(1, 0, 0);
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL stall_at13 got %b exp 1", stall_o); end
      cycle(0, 1, 0);
      n_cmp++; if (rd_addr_o !== 16'h3210) begin n_bad++; $display("FAIL wrap_rd_post got %h exp 3210", rd_addr_o); end
      n_cmp++; if (count_o !== 5'd9) begin n_bad++; $display("FAIL wrap_count_post got %0d exp 9", count_o); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      cycle(4, 0, 0);
      cycle(4, 0, 0);
      cycle(4, 1, 0);
      n_cmp++; if (count_o !== 5'd8) begin n_bad++; $display("FAIL b2b_count got %0d exp 8", count_o); end
      n_cmp++; if (rd_addr_o !== 16'h7654) begin n_bad++; $display("FAIL b2b_rd got %h exp 7654", rd_addr_o); end
      n_cmp++; if (tail_o !== 4'd12) begin n_bad++; $display("FAIL b2b_tail got %0d exp 12", tail_o); end
   endtask

   // Continues from test_back_to_back: count=8, tail=12.
   task automatic test_overflow();
      cycle(4, 0, 0);
      cycle(2, 0, 0);
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL ovf_stall14 got %b exp 1", stall_o); end
      n_cmp++; if (overflow_err_o !== 1'b0) begin n_bad++; $display("FAIL ovf_err_pre got %b exp 0", overflow_err_o); end
      cycle(2, 0, 0);
      n_cmp++; if (count_o !== 5'd14) begin n_bad++; $display("FAIL ovf_count got %0d exp 14", count_o); end
      n_cmp++; if (tail_o !== 4'd2) begin n_bad++; $display("FAIL ovf_tail got %0d exp 2", tail_o); end
      n_cmp++; if (overflow_err_o !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b exp 1", overflow_err_o); end
      cycle(0, 1, 0);
      cycle(0, 0, 1);
      n_cmp++; if (overflow_err_o !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b exp 1", overflow_err_o); end
      cycle(4, 0, 0);
      cycle(4, 0, 0);
      cycle(2, 0, 0);
      n_cmp++; if (count_o !== 5'd10) begin n_bad++; $display("FAIL ovf_refill got %0d exp 10", count_o); end
   endtask

   // Reset is raised between edges with count=10; outputs must settle before the next posedge.
   task automatic test_async_reset();
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL areset_count got %0d exp 0", count_o); end
      n_cmp++; if (tail_o !== 4'd0) begin n_bad++; $display("FAIL areset_tail got %0d exp 0", tail_o); end
      n_cmp++; if (rd_addr_o !== 16'h3210) begin n_bad++; $display("FAIL areset_rd got %h exp 3210", rd_addr_o); end
      n_cmp++; if (overflow_err_o !== 1'b0) begin n_bad++; $display("FAIL areset_err got %b exp 0", overflow_err_o); end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_flush();
      apply_reset();
      cycle(4, 0, 0);
      cycle(4, 0, 0);
      cycle(1, 0, 0);
      n_cmp++; if (count_o !== 5'd9) begin n_bad++; $display("FAIL flush_pre_count got %0d exp 9", count_o); end
      cycle(3, 1, 1);
      n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL flush_count got %0d exp 0", count_o); end
      n_cmp++; if (tail_o !== 4'd0) begin n_bad++; $display("FAIL flush_tail got %0d exp 0", tail_o); end
      n_cmp++; if (rd_addr_o !== 16'h3210) begin n_bad++; $display("FAIL flush_rd got %h exp 3210", rd_addr_o); end
      n_cmp++; if (bundle_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b exp 0", bundle_valid_o); end
   endtask

   task automatic test_random();
      int p;
      bit r, f;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         p = int'($urandom_range(0, 4));
         r = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 29) == 0);
         cycle(p, r, f);
         n_cmp++; if (count_o !== 5'(m_count)) begin n_bad++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, count_o, m_count); end
         n_cmp++; if (tail_o !== 4'(m_tail)) begin n_bad++; $display("FAIL rnd_tail cyc %0d got %0d exp %0d", n, tail_o, m_tail); end
         n_cmp++; if (rd_addr_o !== exp_rd()) begin n_bad++; $display("FAIL rnd_rd cyc %0d got %h exp %h", n, rd_addr_o, exp_rd()); end
         n_cmp++; if (bundle_valid_o !== (m_count >= 4)) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, bundle_valid_o, m_count >= 4); end
         n_cmp++; if (stall_o !== ((16 - m_count) < 4)) begin n_bad++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, stall_o, (16 - m_count) < 4); end
         n_cmp++; if (overflow_err_o !== m_err) begin n_bad++; $display("FAIL rnd_err cyc %0d got %b exp %b", n, overflow_err_o, m_err); end
      end
   endtask

   initial begin
      reset = 1'b1;
      flush_i = 1'b0;
      push_cnt_i = '0;
      dispatch_ready_i = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_wrap();
      test_back_to_back();
      test_overflow();
      test_async_reset();
      test_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
